rom_fetch_unit: RTL and testbench

ROM_FETCH_UNIT -- requirements
Module: rom_fetch_unit

---
 rtl/rom_fetch_unit.sv | 108 ++++++++++
 tb/tb_rom_fetch_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit: instruction-byte prefetcher for a 1-cycle-latency ROM.
// Keeps a 2-entry {addr,data} buffer topped up with a credit rule so the
// buffer cannot overflow, and redirects on JUMP with a single-cycle bubble.
module rom_fetch_unit #(
  parameter logic [7:0] RESET_ADDR = 8'h00
) (
  input  logic       CLK,
  input  logic       RESET_N,
  output logic [7:0] ROM_ADDR,
  input  logic [7:0] ROM_DATA,
  input  logic       JUMP,
  input  logic [7:0] JUMP_ADDR,
  output logic [7:0] INSTR,
  output logic [7:0] INSTR_ADDR,
  output logic       INSTR_VALID,
  input  logic       INSTR_READY
);

  logic [7:0]  pc;
  logic        inflight;
  logic [7:0]  inflight_addr;

  // Shift-style buffer: entry 0 is the head. Empty entries are held at zero,
  // so the head register drives INSTR/INSTR_ADDR directly.
  logic        v0, v1;
  logic [15:0] e0, e1;

  logic        n_v0, n_v1;
  logic [15:0] n_e0, n_e1;

  logic        pop;
  logic        issue;
  logic [2:0]  occupancy;

  // ROM address mux: jump target bypasses PC in the redirect cycle
  always_comb begin
    ROM_ADDR = JUMP ? JUMP_ADDR : pc;
  end

  // Credit check: buffered + in-flight entries after this edge's pop must leave room
  always_comb begin
    pop       = v0 & INSTR_READY & ~JUMP;
    occupancy = {2'b00, v0} + {2'b00, v1} + {2'b00, inflight} - {2'b00, pop};
    issue     = ~JUMP & (occupancy < 3'd2);
  end

  // Next buffer contents for a non-jump edge: pop shifts first, then the
  // returning ROM byte lands in the first free slot
  always_comb begin
    n_v0 = v0;
    n_v1 = v1;
    n_e0 = e0;
    n_e1 = e1;
    if (pop) begin
      n_v0 = v1;
      n_e0 = e1;
      n_v1 = 1'b0;
      n_e1 = '0;
    end
    if (inflight) begin
      if (!n_v0) begin
        n_v0 = 1'b1;
        n_e0 = {inflight_addr, ROM_DATA};
      end else begin
        n_v1 = 1'b1;
        n_e1 = {inflight_addr, ROM_DATA};
      end
    end
  end

  // Fetch state: reset beats jump, jump flushes everything and refetches
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      pc            <= RESET_ADDR;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      v0            <= 1'b0;
      v1            <= 1'b0;
      e0            <= '0;
      e1            <= '0;
    end else if (JUMP) begin
      pc            <= JUMP_ADDR + 8'd1;
      inflight      <= 1'b1;
      inflight_addr <= JUMP_ADDR;
      v0            <= 1'b0;
      v1            <= 1'b0;
      e0            <= '0;
      e1            <= '0;
    end else begin
      v0 <= n_v0;
      v1 <= n_v1;
      e0 <= n_e0;
      e1 <= n_e1;
      if (issue) begin
        inflight      <= 1'b1;
        inflight_addr <= pc;
        pc            <= pc + 8'd1;
      end else begin
        inflight      <= 1'b0;
      end
    end
  end

  assign INSTR_VALID = v0;
  assign INSTR_ADDR  = e0[15:8];
  assign INSTR       = e0[7:0];

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Testbench for rom_fetch_unit: directed scenarios followed by random
// ready/jump/reset traffic, checked cycle by cycle against a queue model.
module tb_rom_fetch_unit;

  localparam logic [7:0] RST_ADDR = 8'h00;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [7:0] ROM_ADDR;
  logic [7:0] ROM_DATA;
  logic       JUMP = 1'b0;
  logic [7:0] JUMP_ADDR = 8'h00;
  logic [7:0] INSTR;
  logic [7:0] INSTR_ADDR;
  logic       INSTR_VALID;
  logic       INSTR_READY = 1'b0;

  rom_fetch_unit #(.RESET_ADDR(RST_ADDR)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .ROM_ADDR    (ROM_ADDR),
    .ROM_DATA    (ROM_DATA),
    .JUMP        (JUMP),
    .JUMP_ADDR   (JUMP_ADDR),
    .INSTR       (INSTR),
    .INSTR_ADDR  (INSTR_ADDR),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY)
  );

  always #5 CLK = ~CLK;

  // ROM with one-cycle read latency, contents addr ^ 8'hA5
  logic [7:0] rom_mem [256];
  initial for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i) ^ 8'hA5;
  always @(posedge CLK) ROM_DATA <= rom_mem[ROM_ADDR];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: addresses requested from the ROM but not yet returned,
  // and addresses whose bytes are buffered for the consumer.
  logic [7:0] m_pc;
  logic [7:0] fly_q[$];
  logic [7:0] buf_q[$];
  bit         known = 0;

  task automatic model_edge(input logic rst_n, input logic jmp, input logic [7:0] jaddr,
                            input logic rdy);
    bit pop, issue;
    int pending;
    if (!rst_n) begin
      m_pc = RST_ADDR;
      fly_q.delete();
      buf_q.delete();
      known = 1;
    end else if (jmp) begin
      buf_q.delete();
      fly_q.delete();
      fly_q.push_back(jaddr);
      m_pc = jaddr + 8'd1;
    end else begin
      pop     = (buf_q.size() > 0) && rdy;
      pending = buf_q.size() + fly_q.size() - (pop ? 1 : 0);
      issue   = pending < 2;
      if (pop) void'(buf_q.pop_front());
      if (fly_q.size() > 0) buf_q.push_back(fly_q.pop_front());
      if (issue) begin
        fly_q.push_back(m_pc);
        m_pc = m_pc + 8'd1;
      end
    end
  endtask

  // One clock: drive inputs, check the ROM address mux, clock, check outputs
  task automatic cycle(input logic rst_n, input logic jmp, input logic [7:0] jaddr,
                       input logic rdy);
    RESET_N     = rst_n;
    JUMP        = jmp;
    JUMP_ADDR   = jaddr;
    INSTR_READY = rdy;
    #1;
    if (known) check("rom_addr", ROM_ADDR, jmp ? jaddr : m_pc);
    @(posedge CLK);
    model_edge(rst_n, jmp, jaddr, rdy);
    #1;
    if (known) begin
      check("instr_valid", {7'b0, INSTR_VALID}, (buf_q.size() > 0) ? 8'h01 : 8'h00);
      check("instr_addr", INSTR_ADDR, (buf_q.size() > 0) ? buf_q[0] : 8'h00);
      check("instr", INSTR, (buf_q.size() > 0) ? rom_mem[buf_q[0]] : 8'h00);
    end
  endtask

  initial begin
    // Reset, including a jump request that reset must override
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b1, 8'h33, 1'b1);
    check("rst_valid", {7'b0, INSTR_VALID}, 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("rst_rom_addr", ROM_ADDR, RST_ADDR);

    // Streaming from reset with READY held high
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    check("release_no_valid", {7'b0, INSTR_VALID}, 8'h00);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    check("first_addr", INSTR_ADDR, 8'h00);
    check("first_instr", INSTR, 8'hA5);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    check("second_instr", INSTR, 8'hA4);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    check("third_instr", INSTR, 8'hA7);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);

    // Back-pressure: fill the buffer and hold
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("hold_addr", INSTR_ADDR, 8'h00);
    check("hold_rom_addr", ROM_ADDR, 8'h02);

    // Jump while the buffer is full drops the buffered bytes
    cycle(1'b1, 1'b1, 8'h40, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    check("jump40_addr", INSTR_ADDR, 8'h40);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    check("jump41_addr", INSTR_ADDR, 8'h41);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);

    // Wrap through 8'hFF
    cycle(1'b1, 1'b1, 8'hFE, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
    check("wrap_addr", INSTR_ADDR, 8'h01);

    // Back-to-back jumps: only the second target is presented
    cycle(1'b1, 1'b1, 8'h10, 1'b1);
    cycle(1'b1, 1'b1, 8'h20, 1'b1);
    check("b2b_no_valid", {7'b0, INSTR_VALID}, 8'h00);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    check("b2b_addr", INSTR_ADDR, 8'h20);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);

    // Mid-stream reset with a simultaneous jump
    cycle(1'b0, 1'b1, 8'h77, 1'b1);
    check("midrst_instr", INSTR, 8'h00);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    check("midrst_restart", INSTR_ADDR, RST_ADDR);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 14) == 0) ? 1'b1 : 1'b0,
            8'($urandom_range(0, 255)),
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
